mc_control_unit: RTL and testbench

Multi-cycle control FSM that sequences the shared MIPS datapath: one memory port, one ALU, register file, immediate extender, PC/IR registers. Each instruction is broken into 3–5 steps, and the unit drives the datapath selects and enables for every step. It also selects sign- vs zero-extension of the 16-bit immediate. It waits on a memory-ready handshake and counts retired instructions.

---
 rtl/mc_ctrl_pkg.sv | 83 ++++++++
 rtl/mc_out_decode.sv | 87 ++++++++
 rtl/mc_control_unit.sv | 113 +++++++++++
 tb/tb_mc_control_unit.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, opcode/funct
// values, datapath select encodings and the control word driven to the datapath.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_R_EXEC,
        S_R_WB,
        S_I_EXEC,
        S_I_WB,
        S_BRANCH,
        S_JUMP,
        S_TRAP
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_OPC   = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        SRC_B_RT      = 2'b00,
        SRC_B_FOUR    = 2'b01,
        SRC_B_IMM     = 2'b10,
        SRC_B_IMM_SH2 = 2'b11
    } alu_src_b_e;

    typedef enum logic [1:0] {
        PC_SRC_ALU    = 2'b00,
        PC_SRC_ALUOUT = 2'b01,
        PC_SRC_JUMP   = 2'b10
    } pc_src_e;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       iord;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        alu_src_b_e alu_src_b;
        alu_op_e    alu_op;
        pc_src_e    pc_src;
        logic       ext_zero;
    } ctrl_t;

    // andi/ori take a zero-extended immediate and let the ALU decode the opcode.
    function automatic logic is_logic_imm(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI);
    endfunction

    function automatic logic is_rtype_funct(input logic [5:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
               (fn == FN_OR)  || (fn == FN_SLT);
    endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Combinational map from FSM state (plus opcode, zero, mem_ready) to the datapath
// control word, and the flag marking the final cycle of a retiring instruction.
module mc_out_decode
    import mc_ctrl_pkg::*;
(
    input  state_e     state,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output ctrl_t      ctrl,
    output logic       retire
);

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        ctrl   = '0;
        retire = 1'b0;
        unique case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRC_B_FOUR;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRC_B_IMM_SH2;
                ctrl.ext_zero  = is_logic_imm(opcode);
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                retire          = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
                retire         = mem_ready;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_RT;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                retire         = 1'b1;
            end
            S_I_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = is_logic_imm(opcode) ? ALU_OPC : ALU_ADD;
                ctrl.ext_zero  = is_logic_imm(opcode);
            end
            S_I_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.ext_zero  = is_logic_imm(opcode);
                retire         = 1'b1;
            end
            // beq compares rs-rt; ALUOut already holds the target from DECODE.
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_RT;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_src    = PC_SRC_ALUOUT;
                ctrl.pc_write  = zero;
                retire         = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_src   = PC_SRC_JUMP;
                ctrl.pc_write = 1'b1;
                retire        = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control FSM: state register, next-state sequencing, sticky
// illegal-instruction flag and retired-instruction counter.
module mc_control_unit
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        iord,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_src,
    output logic        ext_zero,
    output logic        illegal,
    output logic [31:0] retired
);

    logic [1:0]  sync_q, sync_d;
    logic        rst_sync_n;
    state_e      state_q, state_d;
    logic        illegal_q, illegal_d;
    logic [31:0] retired_q, retired_d;
    ctrl_t       ctrl;
    logic        retire;

    // Reset asserts asynchronously but releases two clocks after rst_n rises.
    assign sync_d     = {sync_q[0], 1'b1};
    assign rst_sync_n = sync_q[1];

    // NOTE: sequential state uses non-blocking assignments so all flops sample together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                unique case (opcode)
                    OP_LW, OP_SW:             state_d = S_MEM_ADDR;
                    OP_RTYPE:                 state_d = is_rtype_funct(funct) ? S_R_EXEC : S_TRAP;
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = S_I_EXEC;
                    OP_BEQ:                   state_d = S_BRANCH;
                    OP_J:                     state_d = S_JUMP;
                    default:                  state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
            S_R_EXEC:   state_d = S_R_WB;
            S_I_EXEC:   state_d = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_IDLE;
        endcase

        illegal_d = illegal_q | (state_d == S_TRAP);
        retired_d = retire ? retired_q + 32'd1 : retired_q;
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    mc_out_decode u_out_decode (
        .state     (state_q),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .ctrl      (ctrl),
        .retire    (retire)
    );

    assign pc_write   = ctrl.pc_write;
    assign ir_write   = ctrl.ir_write;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign reg_write  = ctrl.reg_write;
    assign iord       = ctrl.iord;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign pc_src     = ctrl.pc_src;
    assign ext_zero   = ctrl.ext_zero;
    assign illegal    = illegal_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: each instruction pushes its expected per-cycle
// control words, and the drain loop drives inputs and compares on the falling edge.
module tb_mc_control_unit;

    localparam logic [5:0] T_RTYPE = 6'h00;
    localparam logic [5:0] T_J     = 6'h02;
    localparam logic [5:0] T_BEQ   = 6'h04;
    localparam logic [5:0] T_ADDI  = 6'h08;
    localparam logic [5:0] T_ANDI  = 6'h0C;
    localparam logic [5:0] T_ORI   = 6'h0D;
    localparam logic [5:0] T_LW    = 6'h23;
    localparam logic [5:0] T_SW    = 6'h2B;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       iord;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       ext_zero;
        logic       illegal;
    } cw_t;

    typedef struct {
        string      tag;
        cw_t        cw;
        logic [5:0] op;
        logic [5:0] fn;
        logic       mr;
        logic       z;
        logic       inc;
    } step_t;

    logic        clk;
    logic        rst_n;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        pc_write, ir_write, mem_read, mem_write, reg_write;
    logic        iord, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_src;
    logic        ext_zero, illegal;
    logic [31:0] retired;

    cw_t         obs;
    step_t       sb[$];
    logic [31:0] model_ret;
    int          checks;
    int          errors;

    mc_control_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .iord       (iord),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .ext_zero   (ext_zero),
        .illegal    (illegal),
        .retired    (retired)
    );

    assign obs = {pc_write, ir_write, mem_read, mem_write, reg_write, iord, reg_dst,
                  mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, ext_zero, illegal};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    task automatic push(input string tag, input cw_t c, input logic [5:0] op, input logic [5:0] fn,
                        input logic mr, input logic z, input logic inc);
        step_t s;
        s.tag = tag; s.cw = c; s.op = op; s.fn = fn; s.mr = mr; s.z = z; s.inc = inc;
        sb.push_back(s);
    endtask

    // Expected control words for one instruction, straight from the state table.
    task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                              input int f_stall, input int m_stall, input int trap_cycles);
        cw_t  c;
        logic lz;
        lz = (op == T_ANDI) || (op == T_ORI);
        for (int i = 0; i < f_stall; i++) begin
            c = '0; c.mem_read = 1'b1; c.alu_src_b = 2'b01;
            push("fetch_wait", c, op, fn, 1'b0, rb(), 1'b0);
        end
        c = '0; c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = 1'b1; c.pc_write = 1'b1;
        push("fetch", c, op, fn, 1'b1, rb(), 1'b0);
        c = '0; c.alu_src_b = 2'b11; c.ext_zero = lz;
        push("decode", c, op, fn, rb(), rb(), 1'b0);
        if (op == T_LW || op == T_SW) begin
            c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
            push("mem_addr", c, op, fn, rb(), rb(), 1'b0);
            c = '0; c.iord = 1'b1;
            if (op == T_LW) c.mem_read = 1'b1;
            else            c.mem_write = 1'b1;
            for (int i = 0; i < m_stall; i++)
                push(op == T_LW ? "mem_rd_wait" : "mem_wr_wait", c, op, fn, 1'b0, rb(), 1'b0);
            push(op == T_LW ? "mem_rd" : "mem_wr", c, op, fn, 1'b1, rb(), op == T_SW);
            if (op == T_LW) begin
                c = '0; c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
                push("mem_wb", c, op, fn, rb(), rb(), 1'b1);
            end
        end else if (op == T_RTYPE && fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) begin
            c = '0; c.alu_src_a = 1'b1; c.alu_op = 2'b10;
            push("r_exec", c, op, fn, rb(), rb(), 1'b0);
            c = '0; c.reg_write = 1'b1; c.reg_dst = 1'b1;
            push("r_wb", c, op, fn, rb(), rb(), 1'b1);
        end else if (op == T_ADDI || lz) begin
            c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = lz ? 2'b11 : 2'b00;
            c.ext_zero = lz;
            push("i_exec", c, op, fn, rb(), rb(), 1'b0);
            c = '0; c.reg_write = 1'b1; c.ext_zero = lz;
            push("i_wb", c, op, fn, rb(), rb(), 1'b1);
        end else if (op == T_BEQ) begin
            c = '0; c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.pc_write = z;
            push("branch", c, op, fn, rb(), z, 1'b1);
        end else if (op == T_J) begin
            c = '0; c.pc_src = 2'b10; c.pc_write = 1'b1;
            push("jump", c, op, fn, rb(), rb(), 1'b1);
        end else begin
            c = '0; c.illegal = 1'b1;
            for (int i = 0; i < trap_cycles; i++)
                push("trap", c, op, fn, rb(), rb(), 1'b0);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the last popped step.
    task automatic drain(input int n);
        step_t s;
        int    k;
        k = 0;
        while (sb.size() > 0 && (n < 0 || k < n)) begin
            s = sb.pop_front();
            opcode = s.op; funct = s.fn; mem_ready = s.mr; zero = s.z;
            #1;
            checks++;
            if (obs !== s.cw) begin
                errors++;
                $display("FAIL %s op=%02h fn=%02h: control word %05h, expected %05h",
                         s.tag, s.op, s.fn, obs, s.cw);
            end
            checks++;
            if (retired !== model_ret) begin
                errors++;
                $display("FAIL %s_retired: retired %08h, expected %08h", s.tag, retired, model_ret);
            end
            if (s.inc) model_ret = model_ret + 32'd1;
            k++;
            @(negedge clk);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) push("idle", cw_t'('0), 6'h00, 6'h00, rb(), rb(), 1'b0);
        drain(-1);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== cw_t'('0) || retired !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: ctl=%05h retired=%08h, expected all zero", obs, retired);
        end
        model_ret = '0;
        release_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b1; opcode = T_LW; funct = 6'h20;
        @(negedge clk);
        #1;
        checks++;
        if (obs !== cw_t'('0)) begin
            errors++;
            $display("FAIL reset_ctl: %05h, expected 00000", obs);
        end
        checks++;
        if (retired !== 32'd0) begin
            errors++;
            $display("FAIL reset_retired: %08h, expected 00000000", retired);
        end
        model_ret = '0;
        release_reset();
    endtask

    task automatic test_rtype();
        logic [31:0] start;
        start = model_ret;
        push_instr(T_RTYPE, 6'h20, 1'b0, 0, 0, 0);
        drain(-1);
        checks++;
        if (retired !== start + 32'd1) begin
            errors++;
            $display("FAIL add_retired: %08h, expected %08h", retired, start + 32'd1);
        end
    endtask

    task automatic test_lw_stall();
        push_instr(T_LW, 6'h00, 1'b0, 0, 3, 0);
        drain(-1);
    endtask

    task automatic test_branch();
        logic [31:0] start;
        start = model_ret;
        push_instr(T_BEQ, 6'h00, 1'b1, 0, 0, 0);
        push_instr(T_BEQ, 6'h00, 1'b0, 1, 0, 0);
        drain(-1);
        checks++;
        if (retired !== start + 32'd2) begin
            errors++;
            $display("FAIL beq_retired: %08h, expected %08h", retired, start + 32'd2);
        end
    endtask

    task automatic test_imm();
        push_instr(T_ORI,  6'h00, 1'b0, 0, 0, 0);
        push_instr(T_ADDI, 6'h00, 1'b0, 0, 0, 0);
        push_instr(T_ANDI, 6'h3F, 1'b1, 2, 0, 0);
        drain(-1);
    endtask

    task automatic test_trap();
        apply_reset();
        push_instr(T_RTYPE, 6'h20, 1'b0, 0, 0, 0);
        push_instr(6'h3F, 6'h00, 1'b0, 0, 0, 6);
        drain(-1);
        checks++;
        if (illegal !== 1'b1 || mem_read !== 1'b0 || retired !== 32'd1) begin
            errors++;
            $display("FAIL trap_opcode: illegal=%b mem_read=%b retired=%08h, expected 1 0 00000001",
                     illegal, mem_read, retired);
        end
        apply_reset();
        push_instr(T_RTYPE, 6'h00, 1'b0, 0, 0, 5);
        drain(-1);
        apply_reset();
    endtask

    task automatic test_retired_wrap();
        push_instr(T_J, 6'h00, 1'b0, 0, 0, 0);
        drain(1);
        force dut.retired_q = 32'hFFFF_FFFF;
        model_ret = 32'hFFFF_FFFF;
        drain(1);
        release dut.retired_q;
        drain(-1);
        checks++;
        if (retired !== 32'd0) begin
            errors++;
            $display("FAIL retired_wrap: %08h, expected 00000000", retired);
        end
        push_instr(T_J, 6'h00, 1'b0, 0, 0, 0);
        drain(-1);
    endtask

    task automatic test_reset_mid_wr();
        push_instr(T_SW, 6'h00, 1'b0, 0, 10, 0);
        drain(5);
        sb.delete();
        mem_ready = 1'b1;
        #1;
        checks++;
        if (mem_write !== 1'b1 || iord !== 1'b1) begin
            errors++;
            $display("FAIL mid_wr_active: mem_write=%b iord=%b, expected 1 1", mem_write, iord);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== cw_t'('0) || retired !== 32'd0) begin
            errors++;
            $display("FAIL mid_wr_reset: ctl=%05h retired=%08h, expected all zero", obs, retired);
        end
        model_ret = '0;
        release_reset();
    endtask

    task automatic test_back_to_back();
        push_instr(T_SW,    6'h00, 1'b0, 1, 2, 0);
        push_instr(T_LW,    6'h00, 1'b0, 0, 0, 0);
        push_instr(T_RTYPE, 6'h22, 1'b0, 0, 0, 0);
        push_instr(T_RTYPE, 6'h24, 1'b0, 2, 0, 0);
        push_instr(T_RTYPE, 6'h25, 1'b0, 0, 0, 0);
        push_instr(T_RTYPE, 6'h2A, 1'b0, 0, 0, 0);
        push_instr(T_BEQ,   6'h00, 1'b1, 0, 0, 0);
        push_instr(T_ORI,   6'h00, 1'b0, 0, 0, 0);
        push_instr(T_J,     6'h00, 1'b0, 3, 0, 0);
        push_instr(T_SW,    6'h00, 1'b0, 0, 0, 0);
        push_instr(T_LW,    6'h00, 1'b0, 2, 1, 0);
        push_instr(6'h01,   6'h00, 1'b0, 0, 0, 4);
        drain(-1);
        apply_reset();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        model_ret = '0;
        rst_n     = 1'b0;
        opcode    = '0;
        funct     = '0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_rtype();
        test_lw_stall();
        test_branch();
        test_imm();
        test_trap();
        test_retired_wrap();
        test_reset_mid_wr();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
